mux_scan_sequencer: RTL
=======================

# mux_scan_sequencer

Sequencer that drives the select inputs of the 4:1 channel multiplexer and captures its output. On each scan it steps `{s1,s0}` through channels 0..3, waits a programmable settle time per channel, and samples `y`. The four samples are presented as a 4-bit snapshot over a valid/ready handshake. It sits directly upstream of the mux on the select path and directly downstream of it on the data path.

## Interface
- `SETTLE`, default 2: cycles each channel is held before `y` is sampled; legal range 1..15.
- `CONTINUOUS`, default 0: 1 = start a new scan automatically after each accepted snapshot; 0 = return to idle.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request one scan; sampled only in IDLE.
- `y`  input  1  mux output, sampled at the end of each settle window.
- `s1`  output  1  select MSB to mux, registered.
- `s0`  output  1  select LSB to mux, registered.
- `snapshot`  output  4  bit n = `y` sampled while `{s1,s0}` = n.
- `valid`  output  1  snapshot complete and stable.
- `ready`  input  1  consumer accepts snapshot.
- `busy`  output  1  high in SCAN and DONE.
- `frame_cnt`  output  8  count of accepted snapshots, wraps 255 -> 0.

## Operation
- Reset (async, while `rst_n`=0): state=IDLE, `{s1,s0}`=0, settle counter=0, `snapshot`=0, `valid`=0, `busy`=0, `frame_cnt`=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - `{s1,s0}` held at 0.
  - On an edge with `start`=1: settle counter <= 0, sel <= 0, go to SCAN.
  - `snapshot` keeps its previous value.
- SCAN:
  - Counter increments each cycle.
  - On an edge where counter == SETTLE-1: `snapshot[sel]` <= `y`, counter <= 0.
  - If sel==3 at that edge: go to DONE, `valid` <= 1, sel stays 3.
  - Otherwise: sel <= sel+1.
  - `start` is ignored in SCAN.
- DONE:
  - `snapshot` and `valid` are held stable until handshake; `{s1,s0}` = 3.
  - On an edge with `valid`&&`ready`: `frame_cnt` <= `frame_cnt`+1 (mod 256), `valid` <= 0.
    - CONTINUOUS=1: sel <= 0, counter <= 0, go to SCAN.
    - CONTINUOUS=0: sel <= 0, go to IDLE.
  - `start` is ignored in DONE.
- `busy` = (state != IDLE), registered.
- Snapshot bits are overwritten in place during a scan. Consumers may only use `snapshot` while `valid`=1.
- `ready` high outside DONE has no effect.
- Reset asserted mid-scan or in DONE: everything returns to reset values immediately. No partial snapshot survives and no `frame_cnt` increment occurs.

## Timing
- Latency from the edge that samples `start`=1 (E0):
  - channel n sampled at edge E0 + (n+1)*SETTLE;
  - `valid` high after edge E0 + 4*SETTLE.
  - SETTLE=2 gives `valid` 8 cycles after E0; SETTLE=1 gives 4.
- `{s1,s0}` change on the same edge that samples the previous channel. The mux is combinational, so each channel gets exactly SETTLE cycles of stable select before its sample edge.
- With `ready` tied high, `valid` is a single-cycle pulse.
- Back-to-back in CONTINUOUS mode: the next scan's first sample is SETTLE cycles after the handshake edge, so frame period = 4*SETTLE+1 cycles.
- `start` held high continuously in non-continuous mode: a new scan begins on the edge after returning to IDLE.

## Test plan
- Static pattern: mux inputs i0=0, i1=1, i2=0, i3=1; pulse `start`; `ready`=1; SETTLE=2 -> select sequence 0,0,1,1,2,2,3,3; `snapshot`=4'b1010, `valid` one cycle, 8 cycles after E0; `frame_cnt`=1.
- Backpressure: `ready`=0 for 10 cycles after `valid` -> `valid`, `snapshot` and `{s1,s0}`=3 stay stable; change mux inputs meanwhile and confirm `snapshot` does not change; raise `ready` -> `valid` drops next edge; `frame_cnt` increments by exactly 1.
- Start while busy: pulse `start` again mid-scan and in DONE -> no restart; sample edges stay at E0 + 2, 4, 6, 8.
- Async reset mid-scan: drop `rst_n` between clock edges after channel 1 is sampled -> outputs go to reset values before the next edge; a fresh `start` after release produces a full correct snapshot.
- CONTINUOUS=1, SETTLE=1, `ready`=1, inputs 1,1,0,1 -> repeating `snapshot`=4'b1011 every 5 cycles; after 256 frames `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux through channels 0..3, samples its output after a settle window
// per channel, and hands the 4-bit snapshot downstream over valid/ready.
module mux_scan_sequencer #(
    parameter int SETTLE     = 2,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic [3:0] snapshot,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] snap_q, snap_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic [7:0] frame_q, frame_d;

    // Handshake: a snapshot transfers on any rising edge where valid && ready;
    // valid never drops and snapshot never changes until that edge.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                if (start) begin
                    cnt_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    snap_d[sel_q] = y;
                    cnt_d         = 4'd0;
                    if (sel_q == 2'd3) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (valid_q && ready) begin
                    frame_d = frame_q + 8'd1;
                    valid_d = 1'b0;
                    sel_d   = 2'd0;
                    if (CONTINUOUS) begin
                        cnt_d   = 4'd0;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
            snap_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            frame_q <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
        end
    end

    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign snapshot  = snap_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_q;

endmodule
